// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler that lets N_REQ byte producers share one UART TX line.
// Frames are start, 8 data bits LSB-first, optional even parity, stop.
module uart_tx_scheduler #(
  parameter int N_REQ        = 4,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 1
) (
  input  logic                     clk_sis,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [8*N_REQ-1:0]       req_data,
  output logic [N_REQ-1:0]         req_ready,
  output logic                     tx1,
  output logic                     busy,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic                     frame_done
);

  localparam int GW = $clog2(N_REQ);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BAUD_PRE  = BW'(CLKS_PER_BIT - 2);
  localparam logic [GW-1:0] RR_INIT   = GW'(N_REQ - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t          r_state;
  logic [GW-1:0]   r_rr;
  logic [BW-1:0]   r_baud;
  logic [2:0]      r_bit;
  logic [7:0]      r_data;
  logic            r_par;

  logic            w_found;
  logic [GW-1:0]   w_gnt;
  logic [7:0]      w_byte;
  int              w_cand;

  function automatic logic even_parity(input logic [7:0] b);
    return ^b;
  endfunction

  // Round-robin pick: first valid requester after the last one served.
  always_comb begin
    w_found = 1'b0;
    w_gnt   = '0;
    w_byte  = 8'h00;
    w_cand  = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      w_cand = (int'(r_rr) + k) % N_REQ;
      if (!w_found && req_valid[w_cand]) begin
        w_found = 1'b1;
        w_gnt   = GW'(w_cand);
        w_byte  = req_data[8*w_cand +: 8];
      end else begin
        w_found = w_found;
      end
    end
  end

  // Accept strobe is only offered while idle and never while reset is held.
  always_comb begin
    req_ready = '0;
    if (!rst && (r_state == S_IDLE) && w_found) begin
      req_ready[w_gnt] = 1'b1;
    end else begin
      req_ready = '0;
    end
  end

  // Frame sequencer with registered line and status outputs.
  always_ff @(posedge clk_sis) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_rr       <= RR_INIT;
      r_baud     <= '0;
      r_bit      <= 3'd0;
      r_data     <= 8'h00;
      r_par      <= 1'b0;
      tx1        <= 1'b1;
      busy       <= 1'b0;
      grant_id   <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_data   <= w_byte;
            r_par    <= even_parity(w_byte);
            grant_id <= w_gnt;
            r_rr     <= w_gnt;
            r_baud   <= '0;
            r_bit    <= 3'd0;
            busy     <= 1'b1;
            tx1      <= 1'b0;
            r_state  <= S_START;
          end else begin
            tx1 <= 1'b1;
          end
        end
        S_START: begin
          if (r_baud == BAUD_LAST) begin
            r_baud  <= '0;
            tx1     <= r_data[0];
            r_state <= S_DATA;
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        S_DATA: begin
          if (r_baud == BAUD_LAST) begin
            r_baud <= '0;
            if (r_bit == 3'd7) begin
              if (PARITY_EN != 0) begin
                tx1     <= r_par;
                r_state <= S_PARITY;
              end else begin
                tx1     <= 1'b1;
                r_state <= S_STOP;
              end
            end else begin
              r_bit <= r_bit + 3'd1;
              tx1   <= r_data[r_bit + 3'd1];
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        S_PARITY: begin
          if (r_baud == BAUD_LAST) begin
            r_baud  <= '0;
            tx1     <= 1'b1;
            r_state <= S_STOP;
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        S_STOP: begin
          if (r_baud == BAUD_LAST) begin
            r_baud  <= '0;
            r_bit   <= 3'd0;
            busy    <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            // Pulse lands in the final STOP cycle because the output is registered.
            frame_done <= (r_baud == BAUD_PRE);
            r_baud     <= r_baud + 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          tx1     <= 1'b1;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Scoreboard bench: a cycle-level reference model predicts every output and
// queues expected frames, which a serial decoder on tx1 pops and checks.
module tb_uart_tx_scheduler;

  localparam int N = 4;
  localparam int C = 4;
  localparam int L = 11 * C;
  localparam int STOP_SAMPLE = 10 * C + C / 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst = 1'b1;
  logic [N-1:0]     req_valid = '0;
  logic [8*N-1:0]   req_data = '0;
  logic [N-1:0]     req_ready;
  logic             tx1, busy, frame_done;
  logic [1:0]       grant_id;

  logic [N-1:0]     np_valid = '0;
  logic [8*N-1:0]   np_data = '0;
  logic [N-1:0]     np_ready;
  logic             np_tx1, np_busy, np_frame_done;
  logic [1:0]       np_grant_id;

  uart_tx_scheduler #(.N_REQ(N), .CLKS_PER_BIT(C), .PARITY_EN(1)) u_dut (
    .clk_sis(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .tx1(tx1), .busy(busy), .grant_id(grant_id),
    .frame_done(frame_done)
  );

  uart_tx_scheduler #(.N_REQ(N), .CLKS_PER_BIT(C), .PARITY_EN(0)) u_dut_np (
    .clk_sis(clk), .rst(rst), .req_valid(np_valid), .req_data(np_data),
    .req_ready(np_ready), .tx1(np_tx1), .busy(np_busy), .grant_id(np_grant_id),
    .frame_done(np_frame_done)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { int g; logic [7:0] b; } exp_t;
  exp_t exp_q[$];

  bit         m_in = 1'b0;
  int         m_k = 0;
  int         m_rr = N - 1;
  logic [7:0] m_byte = 8'h00;
  logic       m_par = 1'b0;
  logic [N-1:0] m_er;
  int         m_g;
  int         m_idx;
  logic       m_et;

  function automatic logic exp_bit(input int k, input logic [7:0] b, input logic par);
    int bi;
    bi = (k - 1) / C;
    if (bi == 0) return 1'b0;
    if (bi <= 8) return b[bi-1];
    if (bi == 9) return par;
    return 1'b1;
  endfunction

  always @(negedge clk) begin
    cyc++;
    m_er = '0;
    m_g  = -1;
    if (!rst && !m_in) begin
      for (int j = 1; j <= N; j++) begin
        m_idx = (m_rr + j) % N;
        if (m_g < 0 && req_valid[m_idx]) m_g = m_idx;
      end
    end
    if (m_g >= 0) m_er[m_g] = 1'b1;
    m_et = m_in ? exp_bit(m_k, m_byte, m_par) : 1'b1;
    chk("req_ready", 32'(req_ready), 32'(m_er));
    chk("tx1", 32'(tx1), 32'(m_et));
    chk("busy", 32'(busy), 32'(m_in));
    chk("frame_done", 32'(frame_done), 32'(m_in && (m_k == L)));
    if (rst) begin
      m_in = 1'b0;
      m_rr = N - 1;
    end else if (m_in) begin
      if (m_k == L) m_in = 1'b0;
      else m_k++;
    end else if (m_g >= 0) begin
      m_in   = 1'b1;
      m_k    = 1;
      m_byte = req_data[8*m_g +: 8];
      m_par  = ^m_byte;
      m_rr   = m_g;
      exp_q.push_back('{m_g, m_byte});
    end
  end

  // ---------------- serial monitor ----------------
  bit          mon_on = 1'b0;
  bit          mon_have = 1'b0;
  int          mon_cnt = 0;
  logic [10:0] mon_bits;
  exp_t        mon_cur;
  int          frames_done = 0;

  always @(negedge clk) begin
    if (rst) begin
      mon_on = 1'b0;
      exp_q.delete();
    end else begin
      if (!mon_on && tx1 === 1'b0) begin
        mon_on  = 1'b1;
        mon_cnt = 0;
        if (exp_q.size() == 0) begin
          mon_have = 1'b0;
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_frame: start bit with no accepted byte (cycle %0d)", cyc);
        end else begin
          mon_have = 1'b1;
          mon_cur  = exp_q.pop_front();
        end
      end
      if (mon_on) begin
        if (mon_cnt % C == C / 2) mon_bits[mon_cnt / C] = tx1;
        if (mon_cnt == STOP_SAMPLE) begin
          if (mon_have) begin
            chk("frame_start", 32'(mon_bits[0]), 32'd0);
            chk("frame_data", 32'(mon_bits[8:1]), 32'(mon_cur.b));
            chk("frame_parity", 32'(mon_bits[9]), 32'(^mon_cur.b));
            chk("frame_stop", 32'(mon_bits[10]), 32'd1);
            chk("frame_grant_id", 32'(grant_id), 32'(mon_cur.g));
          end
          frames_done++;
          mon_on = 1'b0;
        end
        mon_cnt++;
      end
    end
  end

  // ---------------- handshake observer (for the driver) ----------------
  logic [N-1:0] last_rdy = '0;
  int gnt_log[$];

  always @(negedge clk) begin
    last_rdy = req_ready;
    for (int j = 0; j < N; j++) if (req_ready[j] === 1'b1) gnt_log.push_back(j);
  end

  task automatic step();
    @(posedge clk);
    #1;
    for (int j = 0; j < N; j++) if (last_rdy[j]) req_valid[j] = 1'b0;
  endtask

  task automatic rst_pulse();
    @(posedge clk);
    #1;
    rst = 1'b1;
    req_valid = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic wait_grant(input int j, input int max_cyc);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (req_ready[j] !== 1'b1 && n < max_cyc);
    chk("grant_wait", 32'(req_ready[j]), 32'd1);
    step();
  endtask

  task automatic cycle_rand(input int p_raise, input int p_drop);
    step();
    for (int j = 0; j < N; j++) begin
      if (!req_valid[j]) begin
        req_data[8*j +: 8] = 8'($urandom);
        if ($urandom_range(99) < p_raise) req_valid[j] = 1'b1;
      end else if ($urandom_range(99) < p_drop) begin
        req_valid[j] = 1'b0;
      end
    end
  endtask

  task automatic check_log(input string name, input int e0, input int e1, input int e2);
    chk({name, "_count"}, 32'(gnt_log.size() >= 3), 32'd1);
    if (gnt_log.size() >= 3) begin
      chk(name, 32'(gnt_log[0]), 32'(e0));
      chk(name, 32'(gnt_log[1]), 32'(e1));
      chk(name, 32'(gnt_log[2]), 32'(e2));
    end
  endtask

  int e3[5] = '{0, 1, 2, 3, 0};

  initial begin
    // Reset held with random requests: everything must stay quiet.
    repeat (3) cycle_rand(50, 0);
    @(posedge clk);
    #1;
    req_valid = '0;
    rst = 1'b0;

    // Single byte 8'hA5 from requester 0.
    req_data[7:0] = 8'hA5;
    req_valid = 4'b0001;
    wait_grant(0, 10);
    repeat (50) step();
    chk("single_frame_count", 32'(frames_done), 32'd1);

    // All requesters held valid: strict rotation from requester 0.
    rst_pulse();
    gnt_log.delete();
    for (int j = 0; j < N; j++) req_data[8*j +: 8] = 8'(8'h11 * (j + 1));
    req_valid = '1;
    for (int c = 0; c < 200; c++) begin
      step();
      for (int j = 0; j < N; j++) begin
        if (!req_valid[j]) begin
          req_data[8*j +: 8] = 8'($urandom);
          req_valid[j] = 1'b1;
        end
      end
    end
    chk("rotation_count", 32'(gnt_log.size() >= 5), 32'd1);
    if (gnt_log.size() >= 5) for (int i = 0; i < 5; i++) chk("rotation_order", 32'(gnt_log[i]), 32'(e3[i]));

    // Requester 2 alone, then 1 and 3 arrive mid-frame.
    rst_pulse();
    gnt_log.delete();
    req_data = 32'($urandom);
    req_valid = 4'b0100;
    wait_grant(2, 10);
    repeat (5) step();
    req_valid[1] = 1'b1;
    req_valid[3] = 1'b1;
    wait_grant(3, 60);
    wait_grant(1, 60);
    check_log("late_arrival_order", 2, 3, 1);

    // Reset during data bit 3 aborts the frame and restores the pointer.
    rst_pulse();
    gnt_log.delete();
    req_data = 32'($urandom);
    req_valid = 4'b0100;
    wait_grant(2, 10);
    repeat (16) step();
    rst = 1'b1;
    req_valid = 4'b0101;
    step();
    rst = 1'b0;
    wait_grant(0, 10);
    wait_grant(2, 60);
    check_log("post_reset_order", 2, 0, 2);

    // Random traffic with drops and occasional resets.
    for (int c = 0; c < 1500; c++) begin
      cycle_rand(30, 10);
      rst = ($urandom_range(399) == 0);
    end
    rst = 1'b0;
    req_valid = '0;

    // No-parity instance, all-zero byte: 36 low cycles then 4 high.
    np_data = '0;
    np_valid = 4'b0001;
    begin
      int n;
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (np_ready[0] !== 1'b1 && n < 10);
      chk("np_grant_wait", 32'(np_ready[0]), 32'd1);
    end
    @(posedge clk);
    #1;
    np_valid = '0;
    for (int n = 1; n <= 41; n++) begin
      @(negedge clk);
      chk("np_tx1", 32'(np_tx1), 32'(n > 36));
      chk("np_frame_done", 32'(np_frame_done), 32'(n == 40));
      chk("np_busy", 32'(np_busy), 32'(n <= 40));
    end

    // Drain outstanding frames on the main instance.
    begin
      int n;
      n = 0;
      while ((m_in || mon_on || exp_q.size() != 0) && n < 200) begin
        @(negedge clk);
        n++;
      end
      chk("drain_idle", 32'(m_in || mon_on || exp_q.size() != 0), 32'd0);
    end
    chk("frames_seen", 32'(frames_done > 10), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
